sprite_capture: RTL and testbench
=================================

# sprite_capture

Reads a rectangular 21x30 region of the on-screen frame buffer, starting at a given top-left pixel, and copies it row-major into a local save buffer. It is the read-side counterpart of the sprite drawers, which stream x/y/colour from ROM into the VGA adapter. The game controller runs it before drawing a car so the background under the car can later be restored by replaying the save buffer. One capture takes a fixed 632 cycles regardless of clipping.

## Interface
- WIDTH, 21: sprite width in pixels.
- HEIGHT, 30: sprite height in pixels.
- SCREEN_W, 160: visible columns; pixels with x >= SCREEN_W are off-screen.
- SCREEN_H, 120: visible rows; pixels with y >= SCREEN_H are off-screen.
- clk  in  1  single system clock; all logic is on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- start  in  1  capture request; sampled only in IDLE.
- xin  in  8  top-left x, latched on accepted start.
- yin  in  7  top-left y, latched on accepted start.
- fb_x  out  8  frame-buffer read column.
- fb_y  out  7  frame-buffer read row.
- fb_rd_en  out  1  read strobe; fb_colour is valid exactly 1 cycle later.
- fb_colour  in  3  frame-buffer read data.
- buf_addr  out  10  save-buffer write address, 0..WIDTH*HEIGHT-1.
- buf_data  out  3  save-buffer write data.
- buf_we  out  1  save-buffer write enable.
- busy  out  1  high from the first cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse when the last pixel has been written.

## Operation
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: if start=1, latch xin/yin into x0/y0, clear col, row and idx, and go to READ. Otherwise stay in IDLE.
- READ: each cycle issues pixel idx at (x0+col, y0+row).
  - col counts 0..WIDTH-1. When col wraps to 0, row increments.
  - idx increments every cycle.
  - After issuing idx = WIDTH*HEIGHT-1 (629), go to DRAIN.
- DRAIN: writes the final pixel, then goes to DONE.
- DONE: asserts done for one cycle, then returns to IDLE.
- Coordinate arithmetic: x0+col is computed 9 bits wide and y0+row 8 bits wide, so there is no wrap. A pixel is off-screen when the sum is >= SCREEN_W or >= SCREEN_H.
- On-screen pixel: fb_rd_en=1, fb_x/fb_y = the truncated sums.
- Off-screen pixel: fb_rd_en=0, and the pixel is still written, with buf_data=3'b000. This keeps the buffer dense and the cycle count fixed.
- Write stage is one cycle behind the issue stage:
  - buf_addr = idx delayed 1 cycle.
  - buf_data = fb_colour if the delayed on-screen flag is set, else 0.
  - buf_we = 1 for every pixel.
- start is ignored in READ, DRAIN and DONE. No queueing.
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset mid-capture: on the next edge the block is in IDLE with buf_we=0. No further writes, and no done for the aborted capture.

## Timing
- Cycle 0: start high while in IDLE.
- Pixel k is issued in cycle 1+k and written in cycle 2+k, for k = 0..629.
- Cycle 631: last write, state DRAIN.
- Cycle 632: done=1, busy=1, buf_we=0.
- Cycle 633: IDLE. The earliest new start is accepted here.
- busy is high in cycles 1..632.
- fb_rd_en is never high outside READ.
- buf_we is high in cycles 2..631 only: exactly 630 writes per capture.
- Row wrap: the pixel after (col=20, row=r) is (col=0, row=r+1) in the next cycle, with no bubble.

## Structure
- Shared package sprite_pkg holds:
  - SPRITE_W=21, SPRITE_H=30, SPRITE_PIXELS=630;
  - SCREEN_W=160, SCREEN_H=120;
  - COLOUR_W=3, ADDR_W=10;
  - the FSM state encoding.
- Sub-module raster_counter: holds col/row/idx, with clear, step, and a last flag at idx=SPRITE_PIXELS-1. The drawers can reuse it.
- The save buffer itself is external to this block.

## Test plan
- Capture at (10,20) from a frame buffer model returning colour = (x+y) mod 8:
  - 630 writes in cycles 2..631.
  - buf_addr 0 gets 3'd6.
  - buf_addr 629 gets ((30+49) mod 8) = 3'd7.
  - done in cycle 632 only.
- Bottom clip at (0,100):
  - addresses 0..419 hold model data; 420..629 hold 0;
  - fb_rd_en is low for idx >= 420;
  - done still in cycle 632.
- Right clip at (150,0): in each row, cols 0..9 are read and cols 10..20 are written 0. No fb_x value is >= 160.
- start re-asserted in cycles 5 and 632 is ignored. A start in cycle 633 begins a new capture with its first write in cycle 635.
- resetn low in cycle 300 for one cycle: from cycle 301 onward buf_we=0, busy=0 and done=0. A fresh start afterwards completes normally.
- start held high continuously: captures run back to back, each 633 cycles apart, with no overlapping writes.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and types for the sprite capture/draw blocks.
// Holds sprite and screen geometry, bus widths and the capture FSM encoding.
package sprite_pkg;

  localparam int unsigned SPRITE_W      = 21;
  localparam int unsigned SPRITE_H      = 30;
  localparam int unsigned SPRITE_PIXELS = SPRITE_W * SPRITE_H;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned SCREEN_H = 120;

  localparam int unsigned COLOUR_W = 3;
  localparam int unsigned ADDR_W   = 10;
  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned COL_W    = 5;
  localparam int unsigned ROW_W    = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain,
    StDone
  } state_e;

endpackage

// File: rtl/sprite_raster.sv
// raster_counter: row-major walk over a SPRITE_W x SPRITE_H sprite.
// Ports:
//   clk_i, resetn_i  clock and synchronous active-low reset
//   clear_i          zero col/row/idx (has priority over step_i)
//   step_i           advance one pixel; col wraps into the next row
//   col_o, row_o     current pixel position inside the sprite
//   idx_o            linear pixel index (row * SPRITE_W + col)
//   last_o           high while idx_o is the final pixel
module raster_counter
  import sprite_pkg::*;
(
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             clear_i,
  input  logic             step_i,
  output logic [COL_W-1:0] col_o,
  output logic [ROW_W-1:0] row_o,
  output logic [ADDR_W-1:0] idx_o,
  output logic             last_o
);

  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    idx_d = idx_q;
    if (clear_i) begin
      col_d = '0;
      row_d = '0;
      idx_d = '0;
    end else if (step_i) begin
      idx_d = idx_q + 1'b1;
      if (col_q == COL_W'(SPRITE_W - 1)) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      col_q <= '0;
      row_q <= '0;
      idx_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      idx_q <= idx_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign idx_o  = idx_q;
  assign last_o = (idx_q == ADDR_W'(SPRITE_PIXELS - 1));

endmodule

// File: rtl/sprite_capture.sv
// sprite_capture: copies a SPRITE_W x SPRITE_H frame-buffer region, row-major,
// into an external save buffer. Fixed 632-cycle capture; off-screen pixels are
// not read but still written as colour 0 so the buffer stays dense.
// Ports:
//   clk_i, resetn_i        clock and synchronous active-low reset
//   start_i, xin_i, yin_i  capture request and top-left corner (IDLE only)
//   fb_x_o, fb_y_o         frame-buffer read address
//   fb_rd_en_o             read strobe; fb_colour_i valid one cycle later
//   fb_colour_i            frame-buffer read data
//   buf_addr_o/data_o/we_o save-buffer write port
//   busy_o                 capture in progress (through the done cycle)
//   done_o                 one-cycle pulse after the final write
module sprite_capture
  import sprite_pkg::*;
(
  input  logic                clk_i,
  input  logic                resetn_i,
  input  logic                start_i,
  input  logic [X_W-1:0]      xin_i,
  input  logic [Y_W-1:0]      yin_i,
  output logic [X_W-1:0]      fb_x_o,
  output logic [Y_W-1:0]      fb_y_o,
  output logic                fb_rd_en_o,
  input  logic [COLOUR_W-1:0] fb_colour_i,
  output logic [ADDR_W-1:0]   buf_addr_o,
  output logic [COLOUR_W-1:0] buf_data_o,
  output logic                buf_we_o,
  output logic                busy_o,
  output logic                done_o
);

  state_e            state_q, state_d;
  logic [X_W-1:0]    x0_q, x0_d;
  logic [Y_W-1:0]    y0_q, y0_d;
  logic              cnt_clear, cnt_step, cnt_last;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] idx;

  // One extra bit on each sum so edge-of-screen corners never wrap back on-screen.
  logic [X_W:0]      x_sum;
  logic [Y_W:0]      y_sum;
  logic              issue, on_screen;

  // Write stage, one cycle behind issue to match the frame-buffer read latency.
  logic              we_q, on_q;
  logic [ADDR_W-1:0] addr_q;

  raster_counter u_raster (
    .clk_i    (clk_i),
    .resetn_i (resetn_i),
    .clear_i  (cnt_clear),
    .step_i   (cnt_step),
    .col_o    (col),
    .row_o    (row),
    .idx_o    (idx),
    .last_o   (cnt_last)
  );

  always_comb begin
    state_d   = state_q;
    x0_d      = x0_q;
    y0_d      = y0_q;
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d   = StRead;
          x0_d      = xin_i;
          y0_d      = yin_i;
          cnt_clear = 1'b1;
        end
      end
      StRead: begin
        cnt_step = 1'b1;
        if (cnt_last) state_d = StDrain;
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign issue     = (state_q == StRead);
  assign x_sum     = {1'b0, x0_q} + {{(X_W + 1 - COL_W){1'b0}}, col};
  assign y_sum     = {1'b0, y0_q} + {{(Y_W + 1 - ROW_W){1'b0}}, row};
  assign on_screen = (x_sum < (X_W + 1)'(SCREEN_W)) && (y_sum < (Y_W + 1)'(SCREEN_H));

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
      x0_q    <= '0;
      y0_q    <= '0;
      we_q    <= 1'b0;
      on_q    <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      we_q    <= issue;
      on_q    <= issue & on_screen;
      addr_q  <= issue ? idx : '0;
    end
  end

  assign fb_rd_en_o = issue & on_screen;
  // Address is zeroed when not reading so nothing off-screen ever reaches the bus.
  assign fb_x_o     = fb_rd_en_o ? x_sum[X_W-1:0] : '0;
  assign fb_y_o     = fb_rd_en_o ? y_sum[Y_W-1:0] : '0;
  assign buf_addr_o = addr_q;
  assign buf_data_o = on_q ? fb_colour_i : '0;
  assign buf_we_o   = we_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);

endmodule

// File: tb/tb_sprite_capture.sv
// Self-checking bench for sprite_capture: a frame-buffer model returning
// (x+y) mod 8, a scoreboard of expected writes/done pulses keyed by cycle,
// and one task per scenario.
module tb_sprite_capture;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] xin = '0;
  logic [6:0] yin = '0;
  logic [7:0] fb_x;
  logic [6:0] fb_y;
  logic       fb_rd_en;
  logic [2:0] fb_colour = '0;
  logic [9:0] buf_addr;
  logic [2:0] buf_data;
  logic       buf_we;
  logic       busy;
  logic       done;

  sprite_capture dut (
    .clk_i       (clk),
    .resetn_i    (resetn),
    .start_i     (start),
    .xin_i       (xin),
    .yin_i       (yin),
    .fb_x_o      (fb_x),
    .fb_y_o      (fb_y),
    .fb_rd_en_o  (fb_rd_en),
    .fb_colour_i (fb_colour),
    .buf_addr_o  (buf_addr),
    .buf_data_o  (buf_data),
    .buf_we_o    (buf_we),
    .busy_o      (busy),
    .done_o      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Frame buffer: one-cycle read latency; junk when not reading.
  logic [8:0] fb_sum;
  assign fb_sum = {1'b0, fb_x} + {2'b0, fb_y};
  always @(posedge clk) fb_colour <= fb_rd_en ? fb_sum[2:0] : 3'd5;

  typedef struct {
    int         cyc;
    logic [9:0] addr;
    logic [2:0] data;
  } wr_t;

  wr_t  wq[$];
  int   dq[$];
  wr_t  mon_e;
  int   mon_d;
  int   errors = 0;
  int   checks = 0;
  int   wr_count = 0;
  int   rd_count = 0;
  logic [2:0] mem [0:629];

  task automatic push_capture(input int c, input int x, input int y);
    wr_t e;
    int  px, py;
    for (int k = 0; k < 630; k++) begin
      px     = x + k % 21;
      py     = y + k / 21;
      e.cyc  = c + 2 + k;
      e.addr = 10'(k);
      e.data = (px < 160 && py < 120) ? 3'(px + py) : 3'd0;
      wq.push_back(e);
    end
    dq.push_back(c + 632);
  endtask

  // Called at a negedge with the DUT idle; returns the start cycle.
  task automatic begin_capture(input int x, input int y, output int c);
    start = 1'b1;
    xin   = 8'(x);
    yin   = 7'(y);
    c     = cyc;
    push_capture(c, x, y);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Scoreboard monitor, sampled 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (buf_we) begin
      checks++;
      wr_count++;
      if (buf_addr < 10'd630) mem[buf_addr] = buf_data;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write_unexpected cyc=%0d addr=%0d data=%0d, required no write",
                 cyc, buf_addr, buf_data);
      end else begin
        mon_e = wq.pop_front();
        if (cyc !== mon_e.cyc || buf_addr !== mon_e.addr || buf_data !== mon_e.data) begin
          errors++;
          $display("FAIL write got cyc=%0d addr=%0d data=%0d, required cyc=%0d addr=%0d data=%0d",
                   cyc, buf_addr, buf_data, mon_e.cyc, mon_e.addr, mon_e.data);
        end
      end
    end
    if (done) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected cyc=%0d, required no done", cyc);
      end else begin
        mon_d = dq.pop_front();
        if (cyc !== mon_d || busy !== 1'b1 || buf_we !== 1'b0) begin
          errors++;
          $display("FAIL done got cyc=%0d busy=%0b we=%0b, required cyc=%0d busy=1 we=0",
                   cyc, busy, buf_we, mon_d);
        end
      end
    end
    if (fb_rd_en) begin
      checks++;
      rd_count++;
      if (fb_x >= 8'd160 || fb_y >= 7'd120 || busy !== 1'b1) begin
        errors++;
        $display("FAIL read_bounds got x=%0d y=%0d busy=%0b, required x<160 y<120 busy=1",
                 fb_x, fb_y, busy);
      end
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, buf_we, fb_rd_en} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags got busy=%0b done=%0b we=%0b rd=%0b, required all 0",
               busy, done, buf_we, fb_rd_en);
    end
    checks++;
    if (buf_addr !== 10'd0 || buf_data !== 3'd0 || fb_x !== 8'd0 || fb_y !== 7'd0) begin
      errors++;
      $display("FAIL reset_buses got addr=%0d data=%0d x=%0d y=%0d, required all 0",
               buf_addr, buf_data, fb_x, fb_y);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || buf_we !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset got busy=%0b we=%0b, required 0 0", busy, buf_we);
    end
  endtask

  task automatic test_basic();
    int c;
    wr_count = 0;
    rd_count = 0;
    begin_capture(10, 20, c);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy_c1 got %0b, required 1", busy);
    end
    while (cyc < c + 632) @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || buf_we !== 1'b0) begin
      errors++;
      $display("FAIL basic_c632 got done=%0b busy=%0b we=%0b, required 1 1 0",
               done, busy, buf_we);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_c633 got done=%0b busy=%0b, required 0 0", done, busy);
    end
    checks++;
    if (wr_count !== 630 || wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL basic_count got writes=%0d pending=%0d/%0d, required 630 0/0",
               wr_count, wq.size(), dq.size());
    end
    checks++;
    if (mem[0] !== 3'd6 || mem[629] !== 3'd7) begin
      errors++;
      $display("FAIL basic_corners got mem0=%0d mem629=%0d, required 6 7", mem[0], mem[629]);
    end
    checks++;
    if (rd_count !== 630) begin
      errors++;
      $display("FAIL basic_reads got %0d, required 630", rd_count);
    end
  endtask

  task automatic test_clip(input int x, input int y, input int exp_rd,
                           input int a_in, input logic [2:0] d_in, input int a_out);
    int c;
    wr_count = 0;
    rd_count = 0;
    begin_capture(x, y, c);
    while (cyc < c + 634) @(negedge clk);
    checks++;
    if (rd_count !== exp_rd || wr_count !== 630) begin
      errors++;
      $display("FAIL clip_%0d_%0d got reads=%0d writes=%0d, required %0d 630",
               x, y, rd_count, wr_count, exp_rd);
    end
    checks++;
    if (mem[a_in] !== d_in || mem[a_out] !== 3'd0) begin
      errors++;
      $display("FAIL clip_edge_%0d_%0d got mem[%0d]=%0d mem[%0d]=%0d, required %0d 0",
               x, y, a_in, mem[a_in], a_out, mem[a_out], d_in);
    end
    checks++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL clip_pending_%0d_%0d got %0d/%0d, required 0/0", x, y, wq.size(), dq.size());
    end
  endtask

  task automatic test_ignored_start();
    int c, c2;
    wr_count = 0;
    begin_capture(40, 50, c);
    while (cyc < c + 5) @(negedge clk);
    start = 1'b1;
    xin = 8'd0;
    yin = 7'd0;
    @(negedge clk);
    start = 1'b0;
    while (cyc < c + 632) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    begin_capture(7, 9, c2);
    checks++;
    if (c2 !== c + 633) begin
      errors++;
      $display("FAIL ignored_restart_cycle got %0d, required %0d", c2 - c, 633);
    end
    while (cyc < c2 + 634) @(negedge clk);
    checks++;
    if (wr_count !== 1260 || wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL ignored_count got writes=%0d pending=%0d/%0d, required 1260 0/0",
               wr_count, wq.size(), dq.size());
    end
  endtask

  task automatic test_reset_mid();
    int c;
    wr_count = 0;
    begin_capture(20, 30, c);
    while (cyc < c + 300) @(negedge clk);
    resetn = 1'b0;
    wq.delete();
    dq.delete();
    @(negedge clk);
    resetn = 1'b1;
    checks++;
    if (buf_we !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got we=%0b busy=%0b done=%0b, required 0 0 0",
               buf_we, busy, done);
    end
    repeat (700) @(negedge clk);
    checks++;
    if (wr_count !== 299) begin
      errors++;
      $display("FAIL reset_mid_writes got %0d, required 299", wr_count);
    end
    wr_count = 0;
    begin_capture(5, 5, c);
    while (cyc < c + 634) @(negedge clk);
    checks++;
    if (wr_count !== 630 || wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_fresh got writes=%0d pending=%0d/%0d, required 630 0/0",
               wr_count, wq.size(), dq.size());
    end
  endtask

  task automatic test_back_to_back();
    int c;
    wr_count = 0;
    start = 1'b1;
    xin = 8'd60;
    yin = 7'd40;
    c = cyc;
    for (int n = 0; n < 3; n++) push_capture(c + 633 * n, 60, 40);
    while (cyc < c + 1267) @(negedge clk);
    start = 1'b0;
    while (cyc < c + 1266 + 634) @(negedge clk);
    checks++;
    if (wr_count !== 1890 || wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL back_to_back got writes=%0d pending=%0d/%0d, required 1890 0/0",
               wr_count, wq.size(), dq.size());
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    // Bottom clip: idx 419 is (col 20,row 19) -> (20,119) -> 3; idx 420 is off-screen.
    test_clip(0, 100, 420, 419, 3'd3, 420);
    // Right clip: idx 9 is (159,0) -> 7; idx 10 is x=160, off-screen.
    test_clip(150, 0, 300, 9, 3'd7, 10);
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
